// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for mem_port_arbiter: FSM states and grant identifiers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core (fetch + MEM stage), the arbiter and the memory wrapper.
// The slave modport is the arbiter's view; master is the surrounding core/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      if_req;
    logic [ADDR_WIDTH-1:0]     if_addr;
    logic                      if_done;
    logic [DATA_WIDTH-1:0]     if_rdata;
    logic                      if_err;

    logic                      d_req;
    logic                      d_we;
    logic [ADDR_WIDTH-1:0]     d_addr;
    logic [DATA_WIDTH-1:0]     d_wdata;
    logic [DATA_WIDTH/8-1:0]   d_wstrb;
    logic                      d_done;
    logic [DATA_WIDTH-1:0]     d_rdata;
    logic                      d_err;

    logic                      mem_req;
    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_wstrb;
    logic                      mem_ack;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_done, if_rdata, if_err,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_done, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_done, if_rdata, if_err,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_done, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: bit 0 = fetch, bit 1 = data; ties go to the side not last granted.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == GNT_D) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between fetch and MEM stage, one access in flight.
// Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    localparam int STRB_W = DATA_WIDTH / 8;

    arb_state_e              state_q, state_d;
    logic                    last_q;
    logic [1:0]              req_m, gnt;
    logic                    grant_i, grant_d, finish_ok, finish_to;

    logic                    mem_req_q, mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [STRB_W-1:0]       mem_wstrb_q;

    logic                    if_done_q, if_err_q, d_done_q, d_err_q;
    logic [DATA_WIDTH-1:0]   if_rdata_q, d_rdata_q;

    // A requester whose done pulse is out this cycle is still holding its old request.
    assign req_m = {bus.d_req & ~d_done_q, bus.if_req & ~if_done_q};

    rr_pick2 u_pick (
        .req  (req_m),
        .last (last_q),
        .gnt  (gnt)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt_q;
    logic             to_expire;

    assign to_expire = (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt_q <= '0;
        else if (grant_i || grant_d)
            to_cnt_q <= '0;
        else if (state_q != IDLE && !bus.mem_ack)
            to_cnt_q <= to_cnt_q + 1'b1;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic to_expire;
    assign to_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        finish_ok = 1'b0;
        finish_to = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt[0]) begin
                    state_d = BUSY_I;
                    grant_i = 1'b1;
                end else if (gnt[1]) begin
                    state_d = BUSY_D;
                    grant_d = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                // A completion arriving on the expiry cycle still counts as a normal completion.
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    finish_ok = 1'b1;
                end else if (to_expire) begin
                    state_d   = IDLE;
                    finish_to = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= GNT_D;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            if (grant_i) begin
                last_q      <= GNT_I;
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= bus.if_addr;
                mem_wdata_q <= '0;
                mem_wstrb_q <= '0;
            end else if (grant_d) begin
                last_q      <= GNT_D;
                mem_req_q   <= 1'b1;
                mem_we_q    <= bus.d_we;
                mem_addr_q  <= bus.d_addr;
                mem_wdata_q <= bus.d_wdata;
                mem_wstrb_q <= bus.d_we ? bus.d_wstrb : '0;
            end else if (finish_ok || finish_to) begin
                mem_req_q   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_done_q  <= 1'b0;
            if_err_q   <= 1'b0;
            if_rdata_q <= '0;
            d_done_q   <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            if ((finish_ok || finish_to) && state_q == BUSY_I) begin
                if_done_q  <= 1'b1;
                if_err_q   <= finish_to;
                if_rdata_q <= finish_to ? '0 : bus.mem_rdata;
            end
            if ((finish_ok || finish_to) && state_q == BUSY_D) begin
                d_done_q  <= 1'b1;
                d_err_q   <= finish_to;
                d_rdata_q <= (finish_to || mem_we_q) ? '0 : bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;

    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the timeout section follows MEM_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.d_wstrb   = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req",  32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_if_done",  32'(bus.if_done), 32'd0);
        chk("rst_d_done",   32'(bus.d_done), 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_d_err",    32'(bus.d_err), 32'd0);
        rst_n = 1'b1;
        step();

        // Tie right after reset: fetch first, then data store with unchanged fields
        bus.if_req  = 1'b1; bus.if_addr = 32'h104;
        bus.d_req   = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200;
        bus.d_wdata = 32'h1122_3344; bus.d_wstrb = 4'h5;
        step();
        chk("tie_req_i",   32'(bus.mem_req), 32'd1);
        chk("tie_addr_i",  bus.mem_addr, 32'h104);
        chk("tie_we_i",    32'(bus.mem_we), 32'd0);
        chk("tie_wdata_i", bus.mem_wdata, 32'd0);
        chk("tie_wstrb_i", 32'(bus.mem_wstrb), 32'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA5A5_A5A5;
        step();
        bus.mem_ack = 1'b0;
        chk("tie_if_done",  32'(bus.if_done), 32'd1);
        chk("tie_if_rdata", bus.if_rdata, 32'hA5A5_A5A5);
        chk("tie_if_err",   32'(bus.if_err), 32'd0);
        chk("tie_req_drop", 32'(bus.mem_req), 32'd0);
        bus.if_req = 1'b0;
        step();
        chk("tie_req_d",   32'(bus.mem_req), 32'd1);
        chk("tie_we_d",    32'(bus.mem_we), 32'd1);
        chk("tie_addr_d",  bus.mem_addr, 32'h200);
        chk("tie_wdata_d", bus.mem_wdata, 32'h1122_3344);
        chk("tie_wstrb_d", 32'(bus.mem_wstrb), 32'h5);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        step();
        bus.mem_ack = 1'b0;
        chk("tie_d_done",  32'(bus.d_done), 32'd1);
        chk("tie_d_rdata", bus.d_rdata, 32'd0);
        chk("tie_d_err",   32'(bus.d_err), 32'd0);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        step();
        chk("tie_d_pulse", 32'(bus.d_done), 32'd0);

        // Fairness: both held, grants alternate I,D,I,D,I,D
        bus.if_req = 1'b1; bus.if_addr = 32'h1000;
        bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("rr%0d_req", k),  32'(bus.mem_req), 32'd1);
            chk($sformatf("rr%0d_addr", k), bus.mem_addr, (k % 2 == 0) ? 32'h1000 : 32'h2000);
            bus.mem_ack = 1'b1; bus.mem_rdata = 32'h100 + 32'(k);
            step();
            bus.mem_ack = 1'b0;
            chk($sformatf("rr%0d_if_done", k), 32'(bus.if_done), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d_d_done", k),  32'(bus.d_done),  (k % 2 == 0) ? 32'd0 : 32'd1);
            if (k == 5) begin
                bus.if_req = 1'b0;
                bus.d_req  = 1'b0;
            end
        end
        chk("rr_d_rdata", bus.d_rdata, 32'h105);
        step();
        chk("rr_idle", 32'(bus.mem_req), 32'd0);

        // Fetch only with two memory wait cycles
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        step();
        chk("f_req_n1",  32'(bus.mem_req), 32'd1);
        chk("f_addr_n1", bus.mem_addr, 32'h100);
        step();
        chk("f_req_n2",  32'(bus.mem_req), 32'd1);
        chk("f_done_n2", 32'(bus.if_done), 32'd0);
        step();
        chk("f_req_n3",  32'(bus.mem_req), 32'd1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        step();
        bus.mem_ack = 1'b0;
        chk("f_done_n4",  32'(bus.if_done), 32'd1);
        chk("f_rdata_n4", bus.if_rdata, 32'hDEAD_BEEF);
        chk("f_req_n4",   32'(bus.mem_req), 32'd0);
        bus.if_req = 1'b0;
        step();
        chk("f_pulse", 32'(bus.if_done), 32'd0);
        chk("f_hold",  bus.if_rdata, 32'hDEAD_BEEF);

        // Stray mem_ack in IDLE
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_0000;
        step();
        bus.mem_ack = 1'b0;
        chk("stray_if_done", 32'(bus.if_done), 32'd0);
        chk("stray_d_done",  32'(bus.d_done), 32'd0);
        chk("stray_req",     32'(bus.mem_req), 32'd0);

        // Back-to-back data: new fields on the done cycle are granted one IDLE cycle later
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
        step();
        chk("b2b_addr1", bus.mem_addr, 32'h300);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
        step();
        bus.mem_ack = 1'b0;
        chk("b2b_done1",  32'(bus.d_done), 32'd1);
        chk("b2b_rdata1", bus.d_rdata, 32'h1234_5678);
        bus.d_addr = 32'h304;
        step();
        chk("b2b_idle",  32'(bus.mem_req), 32'd0);
        chk("b2b_nodone", 32'(bus.d_done), 32'd0);
        step();
        chk("b2b_req2",  32'(bus.mem_req), 32'd1);
        chk("b2b_addr2", bus.mem_addr, 32'h304);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
        step();
        bus.mem_ack = 1'b0;
        chk("b2b_done2",  32'(bus.d_done), 32'd1);
        chk("b2b_rdata2", bus.d_rdata, 32'h0BAD_F00D);
        bus.d_req = 1'b0;
        step();

        // Asynchronous reset in the middle of a data access
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h400;
        bus.d_wdata = 32'h55; bus.d_wstrb = 4'hF;
        step();
        chk("mrst_busy", 32'(bus.mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_req_now", 32'(bus.mem_req), 32'd0);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        step();
        chk("mrst_nodone_a", 32'(bus.d_done), 32'd0);
        rst_n = 1'b1;
        step();
        chk("mrst_nodone_b", 32'(bus.d_done), 32'd0);
        chk("mrst_idle",     32'(bus.mem_req), 32'd0);
        bus.if_req = 1'b1; bus.if_addr = 32'h108;
        bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h408;
        step();
        chk("mrst_tie_addr", bus.mem_addr, 32'h108);
        chk("mrst_tie_we",   32'(bus.mem_we), 32'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1;
        step();
        bus.mem_ack = 1'b0;
        chk("mrst_if_done", 32'(bus.if_done), 32'd1);
        bus.if_req = 1'b0;
        step();
        chk("mrst_d_addr", bus.mem_addr, 32'h408);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h600D_CAFE;
        step();
        bus.mem_ack = 1'b0;
        chk("mrst_d_done",  32'(bus.d_done), 32'd1);
        chk("mrst_d_rdata", bus.d_rdata, 32'h600D_CAFE);
        bus.d_req = 1'b0;
        step();

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: four BUSY cycles without mem_ack end the access with an error
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("to_busy%0d", k), 32'(bus.mem_req), 32'd1);
            chk($sformatf("to_nodone%0d", k), 32'(bus.d_done), 32'd0);
        end
        step();
        chk("to_done",  32'(bus.d_done), 32'd1);
        chk("to_err",   32'(bus.d_err), 32'd1);
        chk("to_rdata", bus.d_rdata, 32'd0);
        chk("to_req",   32'(bus.mem_req), 32'd0);
        bus.d_req = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_0000;
        step();
        bus.mem_ack = 1'b0;
        chk("to_late_done",  32'(bus.d_done), 32'd0);
        chk("to_late_rdata", bus.d_rdata, 32'd0);
`else
        // Without the watchdog a silent memory simply keeps the access pending
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("wait_busy%0d", k), 32'(bus.mem_req), 32'd1);
            chk($sformatf("wait_nodone%0d", k), 32'(bus.d_done), 32'd0);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5;
        step();
        bus.mem_ack = 1'b0;
        chk("wait_done",  32'(bus.d_done), 32'd1);
        chk("wait_err",   32'(bus.d_err), 32'd0);
        chk("wait_rdata", bus.d_rdata, 32'h5);
        bus.d_req = 1'b0;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
